// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: packs audio samples into FFT frames and tags, checks and counts the returned spectrum.
module fft_frame_ctrl #(
  parameter int FFT_PTS  = 1024,
  parameter int LOG2_PTS = 10,
  parameter int IN_W     = 24,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                audio_valid,
  output logic                audio_ready,
  input  logic [IN_W-1:0]     audio_data,
  output logic                sink_valid,
  input  logic                sink_ready,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [1:0]          sink_error,
  output logic [DATA_W-1:0]   sink_real,
  output logic [DATA_W-1:0]   sink_imag,
  output logic [12:0]         fftpts_in,
  output logic                inverse,
  input  logic                source_valid,
  output logic                source_ready,
  input  logic                source_sop,
  input  logic                source_eop,
  input  logic [1:0]          source_error,
  input  logic [DATA_W-1:0]   source_real,
  input  logic [DATA_W-1:0]   source_imag,
  output logic                bin_valid,
  input  logic                bin_ready,
  output logic [DATA_W-1:0]   bin_real,
  output logic [DATA_W-1:0]   bin_imag,
  output logic [LOG2_PTS-1:0] bin_index,
  output logic                bin_last,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_OUT, ERROR} state_t;
  localparam logic [LOG2_PTS-1:0] LAST = LOG2_PTS'(FFT_PTS - 1);
  state_t state, state_nx;
  logic [LOG2_PTS-1:0] in_cnt, out_cnt;
  logic stream, wait_out, in_xfer, out_xfer, frame_end;
  logic bad_frame, bad_core, fe, ce, err_evt, clr;
  assign stream      = state == STREAM;
  assign wait_out    = state == WAIT_OUT;
  assign busy        = state != IDLE;
  assign sink_valid  = stream & audio_valid;
  assign audio_ready = stream & sink_ready;
  assign sink_sop    = stream && in_cnt == '0;
  assign sink_eop    = stream && in_cnt == LAST;
  assign sink_real   = {{(DATA_W-IN_W){audio_data[IN_W-1]}}, audio_data};
  assign sink_imag   = '0;
  assign sink_error  = 2'b00;
  assign fftpts_in   = 13'(FFT_PTS);
  assign inverse     = 1'b0;
  assign in_xfer     = sink_valid & sink_ready;
  // Beat checks are evaluated on valid alone so bin_valid never depends on bin_ready.
  assign bad_frame    = (source_sop != (out_cnt == '0)) || (source_eop != (out_cnt == LAST));
  assign bad_core     = source_error != 2'b00;
  assign source_ready = wait_out ? bin_ready : state == ERROR;
  assign bin_valid    = wait_out & source_valid & ~(bad_frame | bad_core);
  assign bin_real     = source_real;
  assign bin_imag     = source_imag;
  assign bin_index    = out_cnt;
  assign bin_last     = wait_out && out_cnt == LAST;
  assign out_xfer     = bin_valid & bin_ready;
  assign frame_end    = out_xfer && out_cnt == LAST;
  assign fe      = source_valid & ((wait_out & source_ready & bad_frame) | state == IDLE | stream);
  assign ce      = wait_out & source_valid & source_ready & bad_core;
  assign err_evt = fe | ce;
  always_comb begin
    state_nx = state;
    if (err_evt) state_nx = ERROR;
    else if (state == IDLE) state_nx = enable ? STREAM : IDLE;
    else if (stream) state_nx = (in_xfer && sink_eop) ? WAIT_OUT : STREAM;
    else if (wait_out) state_nx = frame_end ? (enable ? STREAM : IDLE) : WAIT_OUT;
    else state_nx = enable ? ERROR : IDLE;
  end
  assign clr = state_nx == IDLE || state_nx == ERROR;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      state       <= state_nx;
      in_cnt      <= clr ? '0 : in_xfer ? (sink_eop ? '0 : in_cnt + LOG2_PTS'(1)) : in_cnt;
      out_cnt     <= clr ? '0 : out_xfer ? (frame_end ? '0 : out_cnt + LOG2_PTS'(1)) : out_cnt;
      frame_done  <= frame_end;
      frame_count <= frame_count + 16'(frame_end);
      err         <= err | err_evt;
      err_code    <= err_evt ? {fe, ce} : err_code;
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench acting as audio source, FFT core and bin consumer.
module tb_fft_frame_ctrl;
  localparam int PTS = 1024;
  logic clk = 0, reset_n, enable, audio_valid, audio_ready, sink_valid, sink_ready, sink_sop, sink_eop;
  logic [23:0] audio_data;
  logic [1:0] sink_error, source_error, err_code;
  logic [31:0] sink_real, sink_imag, source_real, source_imag, bin_real, bin_imag;
  logic [12:0] fftpts_in;
  logic inverse, source_valid, source_ready, source_sop, source_eop, bin_valid, bin_ready, bin_last;
  logic frame_done, err, busy;
  logic [9:0] bin_index;
  logic [15:0] frame_count;
  int checks = 0, failures = 0, done_cnt = 0, done_base, frm = 0;

  fft_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .audio_valid(audio_valid), .audio_ready(audio_ready), .audio_data(audio_data),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_error(sink_error), .sink_real(sink_real), .sink_imag(sink_imag),
    .fftpts_in(fftpts_in), .inverse(inverse),
    .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error), .source_real(source_real),
    .source_imag(source_imag), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_real(bin_real), .bin_imag(bin_imag), .bin_index(bin_index), .bin_last(bin_last),
    .frame_done(frame_done), .frame_count(frame_count), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Feed n samples; drop enable when sample drop_at is offered.
  task automatic send(input int n, input int drop_at, input bit rnd, input bit neg);
    int i, t, bad, d;
    bit acc;
    i = 0; t = 0; bad = 0;
    while (i < n && t < 20000) begin
      d = neg ? i - 512 : i;
      audio_valid = 1; audio_data = 24'(d);
      sink_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == drop_at) enable = 0;
      #1;
      if (sink_valid !== 1'b1 || audio_ready !== sink_ready || sink_real !== 32'(d) ||
          sink_imag !== 32'd0 || sink_error !== 2'b00 || sink_sop !== (i == 0) ||
          sink_eop !== (i == PTS - 1) || fftpts_in !== 13'd1024 || inverse !== 1'b0) bad++;
      if (d == -1) check("sext_minus1", sink_real, 32'hFFFF_FFFF);
      acc = sink_ready;
      @(posedge clk); #1; t++;
      if (acc) i++;
    end
    audio_valid = 0; sink_ready = 0;
    check("send_beats_bad", bad, 0);
    check("send_no_timeout", 32'(t < 20000), 1);
  endtask

  // Act as the FFT core output; err_bin >= 0 injects an eop (or core error) on that bin.
  task automatic drain(input int err_bin, input bit is_core, input bit rnd);
    int b, t, bad, last;
    bit acc;
    b = 0; t = 0; bad = 0; last = err_bin >= 0 ? err_bin : PTS - 1; frm++;
    while (b <= last && t < 20000) begin
      source_valid = 1; source_sop = (b == 0); source_eop = (b == PTS - 1); source_error = 0;
      source_real = 32'(b * 3 + frm); source_imag = ~32'(b);
      if (b == err_bin) begin
        if (is_core) source_error = 2'b01;
        else source_eop = 1;
      end
      bin_ready = (rnd && b != err_bin) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bin_valid !== (b != err_bin) || source_ready !== bin_ready) bad++;
      if (b != err_bin && (bin_index !== 10'(b) || bin_real !== 32'(b * 3 + frm) ||
          bin_imag !== ~32'(b) || bin_last !== (b == PTS - 1))) bad++;
      acc = bin_ready;
      @(posedge clk); #1; t++;
      if (acc) b++;
    end
    if (err_bin < 0) check("frame_done_pulse", 32'(frame_done), 1);
    source_valid = 0; source_sop = 0; source_eop = 0; source_error = 0; bin_ready = 0;
    check("drain_beats_bad", bad, 0);
    check("drain_no_timeout", 32'(t < 20000), 1);
  endtask

  task automatic do_reset();
    reset_n = 0; #1;
    check("reset_err", 32'(err), 0);
    check("reset_err_code", 32'(err_code), 0);
    step(); reset_n = 1; enable = 1; step();
  endtask

  initial begin
    reset_n = 0; enable = 0; audio_valid = 0; audio_data = 0; sink_ready = 0;
    source_valid = 0; source_sop = 0; source_eop = 0; source_error = 0;
    source_real = 0; source_imag = 0; bin_ready = 0;
    step(); step();
    check("rst_audio_ready", 32'(audio_ready), 0);
    check("rst_sink_valid", 32'(sink_valid), 0);
    check("rst_source_ready", 32'(source_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_err", 32'(err), 0);
    reset_n = 1; enable = 1; step();
    check("start_busy", 32'(busy), 1);
    // Full frame with continuous handshakes.
    send(PTS, -1, 0, 0);
    drain(-1, 0, 0);
    check("fc_after_first", 32'(frame_count), 1);
    // Reset in the middle of an input frame.
    send(500, -1, 1, 1);
    audio_valid = 1; sink_ready = 1; reset_n = 0; #1;
    check("midrst_audio_ready", 32'(audio_ready), 0);
    check("midrst_sink_valid", 32'(sink_valid), 0);
    check("midrst_frame_count", 32'(frame_count), 0);
    check("midrst_busy", 32'(busy), 0);
    audio_valid = 0; sink_ready = 0;
    step(); reset_n = 1; step();
    // Three back-to-back frames with random backpressure on both sides.
    done_base = done_cnt;
    for (int k = 0; k < 3; k++) begin
      send(PTS, -1, 1, 1);
      drain(-1, 0, 1);
      check("fc_random", 32'(frame_count), 32'(k + 1));
    end
    step();
    check("done_pulses", 32'(done_cnt - done_base), 3);
    // Premature eop on bin 1000.
    send(PTS, -1, 0, 0);
    drain(1000, 0, 0);
    check("eop_err", 32'(err), 1);
    check("eop_err_code", 32'(err_code), 2);
    source_valid = 1; #1;
    check("error_flush_ready", 32'(source_ready), 1);
    check("error_bin_valid", 32'(bin_valid), 0);
    check("error_busy", 32'(busy), 1);
    source_valid = 0; enable = 0; step();
    check("error_to_idle_busy", 32'(busy), 0);
    check("error_sticky", 32'(err), 1);
    check("error_code_kept", 32'(err_code), 2);
    do_reset();
    // Core error on bin 5.
    send(PTS, -1, 0, 1);
    drain(5, 1, 0);
    check("core_err", 32'(err), 1);
    check("core_err_code", 32'(err_code), 1);
    enable = 0; step();
    do_reset();
    // Drop enable mid-frame: frame still completes and drains.
    send(PTS, 300, 1, 0);
    check("drop_waitout_busy", 32'(busy), 1);
    drain(-1, 0, 1);
    audio_valid = 1; sink_ready = 1; #1;
    check("drop_idle_busy", 32'(busy), 0);
    check("drop_idle_audio_ready", 32'(audio_ready), 0);
    check("drop_frame_count", 32'(frame_count), 1);
    step();
    check("drop_stays_idle", 32'(busy), 0);
    audio_valid = 0; sink_ready = 0;
    // Stray FFT output while idle is a framing error.
    source_valid = 1; step(); source_valid = 0;
    check("stray_err", 32'(err), 1);
    check("stray_err_code", 32'(err_code), 2);
    check("stray_busy", 32'(busy), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
